// File: rtl/cic_pkg.sv
// Shared CIC definitions: internal register width, PDM bit mapping, stage-count limit.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package cic_pkg;

   // Largest supported number of integrator/comb stage pairs
   localparam int CIC_MAX_N = 6;

   // Internal width: 2-bit signed input plus N*log2(R*M) bits of growth
   function automatic int cic_width(input int n, input int r, input int m);
      return 2 + n * $clog2(r * m);
   endfunction

   // PDM 1 -> +1, PDM 0 -> -1
   function automatic logic signed [1:0] pdm_to_signed(input logic b);
      return b ? 2'sb01 : 2'sb11;
   endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: N-stage integrator chain plus N-stage comb chain; CIC_ROUNDING_EN selects round-half-up with saturation.
// Latency: integrators absorb a sample on its accepting edge; the output word is registered on the edge after the decimation event.
// Backpressure: none; every accepted sample and every decimation event is consumed.
module cic_channel
   import cic_pkg::*;
#(
   parameter int N  = 3,
   parameter int M  = 1,
   parameter int W  = 14,
   parameter int OW = 16
) (
   input  logic          lr_clock,
   input  logic          i_reset_n,
   input  logic          sample_vld,
   input  logic          pdm_dat,
   input  logic          dec_vld,
   output logic [OW-1:0] pcm_dat
);

   logic signed [1:0] x2;
   logic [W-1:0]      x_ext;
   logic [W-1:0]      integ     [N];
   logic [W-1:0]      integ_nxt [N];
   logic [W-1:0]      comb_dly  [N][M];
   logic [W-1:0]      comb_in   [N];
   logic [W-1:0]      comb_out;
   logic [W-1:0]      acc_i;
   logic [W-1:0]      acc_c;
   logic [OW-1:0]     scaled;

   assign x2    = pdm_to_signed(pdm_dat);
   assign x_ext = {{(W-2){x2[1]}}, x2};

   // Next integrator values: every stage absorbs the already-updated output of the stage before it
   always_comb begin
      acc_i = x_ext;
      for (int j = 0; j < N; j++) begin
         acc_i        = integ[j] + acc_i;
         integ_nxt[j] = acc_i;
      end
   end

   // Integrators advance only on accepted samples; wrap-around is cancelled later by the combs
   always_ff @(posedge lr_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int j = 0; j < N; j++) integ[j] <= '0;
      end else if (sample_vld) begin
         for (int j = 0; j < N; j++) integ[j] <= integ_nxt[j];
      end
   end

   // Comb chain y = x - x[-M], purely combinational from the last integrator to the output register
   always_comb begin
      acc_c = integ[N-1];
      for (int j = 0; j < N; j++) begin
         comb_in[j] = acc_c;
         acc_c      = acc_c - comb_dly[j][M-1];
      end
      comb_out = acc_c;
   end

   // Output scaling to OW bits: sign-extend when wider, otherwise keep the top OW bits
   generate
      if (OW > W) begin : g_wide
         assign scaled = {{(OW-W){comb_out[W-1]}}, comb_out};
      end else if (OW == W) begin : g_same
         assign scaled = comb_out;
      end else begin : g_narrow
`ifdef CIC_ROUNDING_EN
         localparam logic [W:0] HALF = (W+1)'(1) << (W - OW - 1);
         logic [W:0] rnd;
         logic       unused_lsbs;
         assign rnd         = {comb_out[W-1], comb_out} + HALF;
         // Only a positive value can overflow when adding the half-LSB; clamp to the largest OW-bit word
         assign scaled      = (rnd[W] != rnd[W-1]) ? {1'b0, {(OW-1){1'b1}}} : rnd[W-1 -: OW];
         assign unused_lsbs = ^rnd[W-OW-1:0];
`else
         logic unused_lsbs;
         assign scaled      = comb_out[W-1 -: OW];
         assign unused_lsbs = ^comb_out[W-OW-1:0];
`endif
      end
   endgenerate

   // Comb delay lines and the output word move once per decimation event
   always_ff @(posedge lr_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int j = 0; j < N; j++) begin
            for (int m = 0; m < M; m++) comb_dly[j][m] <= '0;
         end
         pcm_dat <= '0;
      end else if (dec_vld) begin
         for (int j = 0; j < N; j++) begin
            comb_dly[j][0] <= comb_in[j];
            for (int m = 1; m < M; m++) comb_dly[j][m] <= comb_dly[j][m-1];
         end
         pcm_dat <= scaled;
      end
   end

endmodule

// File: rtl/cic_decimator.sv
// Multi-channel CIC decimator, PDM bits in, signed PCM words out; CIC_ROUNDING_EN enables rounded narrow outputs.
// Latency: the R-th accepted sample at edge k gives o_data/o_valid at edge k+1; o_valid is a one-cycle pulse.
// Backpressure: none; downstream must take every o_valid pulse.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int CH = 2,
   parameter int N  = 3,
   parameter int R  = 16,
   parameter int M  = 1,
   parameter int OW = 16
) (
   input  logic               lr_clock,
   input  logic               i_reset_n,
   input  logic               i_valid,
   input  logic [CH-1:0]      i_data,
   output logic               o_valid,
   output logic [CH*OW-1:0]   o_data
);

   localparam int W  = cic_width(N, R, M);
   localparam int CW = $clog2(R);

   logic [CW-1:0] smp_cnt;
   logic          dec_vld;
   logic          dec_pend;

   // The block closes when an accepted sample arrives with the counter at R-1
   assign dec_vld = i_valid && (smp_cnt == CW'(R - 1));

   // Shared sample counter, 0..R-1, counting accepted samples only
   always_ff @(posedge lr_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         smp_cnt <= '0;
      end else if (dec_vld) begin
         smp_cnt <= '0;
      end else if (i_valid) begin
         smp_cnt <= smp_cnt + 1'b1;
      end
   end

   // Decimation event is registered so the combs see integrators that include the R-th sample
   always_ff @(posedge lr_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         dec_pend <= 1'b0;
         o_valid  <= 1'b0;
      end else begin
         dec_pend <= dec_vld;
         o_valid  <= dec_pend;
      end
   end

   // Independent filter per channel, all driven by the shared strobes
   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         cic_channel #(
            .N  (N),
            .M  (M),
            .W  (W),
            .OW (OW)
         ) u_ch (
            .lr_clock   (lr_clock),
            .i_reset_n  (i_reset_n),
            .sample_vld (i_valid),
            .pdm_dat    (i_data[c]),
            .dec_vld    (dec_pend),
            .pcm_dat    (o_data[c*OW +: OW])
         );
      end
   endgenerate

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: FIR-equivalent reference model feeding a scoreboard of expected words.
// Latency: expected words are due two bench cycles after the driving negedge of the R-th sample.
// Backpressure: none; every o_valid pulse is compared.
module tb_cic_decimator;

   localparam int CH  = 2;
   localparam int N   = 3;
   localparam int R   = 16;
   localparam int M   = 1;
   localparam int OW  = 16;
   localparam int OWN = 8;
   localparam int BL  = R * M;
   localparam int L   = N * (BL - 1) + 1;

   logic               lr_clock = 1'b0;
   logic               i_reset_n;
   logic               i_valid;
   logic [CH-1:0]      i_data;
   logic               o_valid;
   logic [CH*OW-1:0]   o_data;
   logic               o_valid_n;
   logic [CH*OWN-1:0]  o_data_n;

   typedef struct {
      int w0;
      int w1;
      int n0;
      int n1;
      int due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   hist0[$];
   int   hist1[$];
   int   h[L];
   int   hb[L];
   int   ht[L];
   int   blk_cnt = 0;
   int   cyc     = 0;
   int   out_idx = 0;
   int   tests   = 0;
   int   fails   = 0;
   bit   st_en   = 1'b0;
   int   st0     = 0;
   int   st1     = 0;

   always #5 lr_clock = ~lr_clock;

   cic_decimator #(.CH(CH), .N(N), .R(R), .M(M), .OW(OW)) dut (
      .lr_clock  (lr_clock),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_valid   (o_valid),
      .o_data    (o_data)
   );

   cic_decimator #(.CH(CH), .N(N), .R(R), .M(M), .OW(OWN)) dut_n (
      .lr_clock  (lr_clock),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_valid   (o_valid_n),
      .o_data    (o_data_n)
   );

   task automatic check(input string tag, input int obs, input int exp_v);
      tests++;
      if (obs != exp_v) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Reference: the CIC equals an FIR whose taps are N cascaded length-R*M boxcars
   function automatic int fir_out(input int ch);
      int n, acc, idx, x;
      n   = hist0.size();
      acc = 0;
      for (int k = 0; k < L; k++) begin
         idx = n - 1 - k;
         if (idx >= 0) begin
            x   = (ch == 0) ? hist0[idx] : hist1[idx];
            acc = acc + h[k] * x;
         end
      end
      return acc;
   endfunction

   // 14-bit value scaled to 8 bits (6 LSBs dropped)
   function automatic int narrow(input int y);
      int t;
`ifdef CIC_ROUNDING_EN
      t = (y + 32) >>> 6;
      if (t > 127) t = 127;
`else
      t = y >>> 6;
`endif
      return t;
   endfunction

   always @(posedge lr_clock) cyc <= cyc + 1;

   task automatic drive(input logic v, input logic [CH-1:0] d);
      exp_t e;
      @(negedge lr_clock);
      i_valid = v;
      i_data  = d;
      if (v) begin
         hist0.push_back(d[0] ? 1 : -1);
         hist1.push_back(d[1] ? 1 : -1);
         blk_cnt++;
         if (blk_cnt == R) begin
            blk_cnt = 0;
            e.w0  = fir_out(0);
            e.w1  = fir_out(1);
            e.n0  = narrow(e.w0);
            e.n1  = narrow(e.w1);
            e.due = cyc + 2;
            exp_q.push_back(e);
         end
      end
   endtask

   // Asynchronous reset dropped mid-cycle; outputs must clear without waiting for a clock edge
   task automatic do_reset();
      @(posedge lr_clock);
      #2;
      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      #1;
      check("rst_vld",   int'(o_valid), 0);
      check("rst_dat",   int'(o_data), 0);
      check("rst_vld_n", int'(o_valid_n), 0);
      check("rst_dat_n", int'(o_data_n), 0);
      hist0.delete();
      hist1.delete();
      exp_q.delete();
      blk_cnt = 0;
      out_idx = 0;
      repeat (2) @(negedge lr_clock);
      i_reset_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge lr_clock);
      check("drain", exp_q.size(), 0);
   endtask

   task automatic run_pat(input logic [CH-1:0] pe, input logic [CH-1:0] po, input int sp,
                          input int nblk, input int s0, input int s1);
      do_reset();
      st0   = s0;
      st1   = s1;
      st_en = 1'b1;
      for (int i = 0; i < nblk * R; i++) begin
         drive(1'b1, (i % 2 == 0) ? pe : po);
         for (int k = 1; k < sp; k++) drive(1'b0, CH'($urandom));
      end
      drive(1'b0, '0);
      drain();
      st_en = 1'b0;
   endtask

   // Scoreboard: every o_valid pops one expectation and checks values, timing and the narrow instance
   always @(negedge lr_clock) begin
      if (i_reset_n && o_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_vld", int'(o_valid), 0);
         end else begin
            mon_e = exp_q.pop_front();
            out_idx++;
            check("w0",      $signed(o_data[OW-1:0]),      mon_e.w0);
            check("w1",      $signed(o_data[2*OW-1:OW]),   mon_e.w1);
            check("vld_n",   int'(o_valid_n),              1);
            check("n0",      $signed(o_data_n[OWN-1:0]),   mon_e.n0);
            check("n1",      $signed(o_data_n[2*OWN-1:OWN]), mon_e.n1);
            check("latency", cyc,                          mon_e.due);
            if (st_en && out_idx > N * M) begin
               check("steady0",   $signed(o_data[OW-1:0]),        st0);
               check("steady1",   $signed(o_data[2*OW-1:OW]),     st1);
               check("steady_n0", $signed(o_data_n[OWN-1:0]),     narrow(st0));
               check("steady_n1", $signed(o_data_n[2*OWN-1:OWN]), narrow(st1));
            end
         end
      end else if (i_reset_n && o_valid_n) begin
         check("vld_n_spur", int'(o_valid_n), 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int acc;
      for (int k = 0; k < L; k++) hb[k] = (k < BL) ? 1 : 0;
      for (int s = 1; s < N; s++) begin
         for (int k = 0; k < L; k++) begin
            acc = 0;
            for (int j = 0; j < BL; j++) if (k - j >= 0) acc = acc + hb[k-j];
            ht[k] = acc;
         end
         for (int k = 0; k < L; k++) hb[k] = ht[k];
      end
      for (int k = 0; k < L; k++) h[k] = hb[k];

      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      i_data    = '0;

      // Constant, alternating and split-channel patterns at full rate
      run_pat(2'b11, 2'b11, 1, 8,  4096,  4096);
      run_pat(2'b00, 2'b00, 1, 8, -4096, -4096);
      run_pat(2'b11, 2'b00, 1, 8,     0,     0);
      run_pat(2'b01, 2'b01, 1, 8,  4096, -4096);
      // One valid cycle in three, random data on idle cycles
      run_pat(2'b11, 2'b11, 3, 6,  4096,  4096);

      // Random data with random gaps, reference model only
      do_reset();
      for (int i = 0; i < 400; i++) drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, CH'($urandom));
      drive(1'b0, '0);
      drain();

      // Reset in the middle of a block: the partial count must be discarded
      do_reset();
      for (int i = 0; i < 3 * R + 10; i++) drive(1'b1, 2'b11);
      drive(1'b0, '0);
      drain();
      do_reset();
      for (int i = 0; i < R; i++) drive(1'b1, 2'b11);
      drive(1'b0, '0);
      drain();

      repeat (4) @(negedge lr_clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised multi-channel CIC decimation filter converting 1-bit PDM microphone streams into signed PCM words. It sits directly after the PDM capture logic on the `lr_clock` domain and feeds the downstream beamforming/FIR stages. Stage count, decimation ratio, differential delay, channel count and output width are all generic, and every output word is qualified by a valid strobe.

## Interface
Parameters:
- `CH`, 2, number of independent PDM channels
- `N`, 3, number of integrator/comb stage pairs (1..6)
- `R`, 16, decimation factor (2..256)
- `M`, 1, comb differential delay (1 or 2)
- `OW`, 16, output word width per channel

Ports:
- `lr_clock`  input  1  sole clock; all state changes on rising edge
- `i_reset_n`  input  1  asynchronous, active-low reset
- `i_valid`  input  1  qualifies `i_data` this cycle
- `i_data`  input  CH  one PDM bit per channel; bit c = channel c
- `o_valid`  output  1  one-cycle pulse, `o_data` holds new words
- `o_data`  output  CH*OW  signed PCM; channel c at [c*OW +: OW]

## Operation
- Input mapping: PDM 1 → +1, 0 → −1 (2-bit signed).
- Internal width `W = 2 + N*clog2(R*M)`; all integrator/comb registers are W bits, two's complement, modular wrap (wrap in integrators is required and cancelled by the combs).
- Integrators: N cascaded accumulators per channel, updated only when `i_valid`=1; idle cycles hold state.
- Decimation counter: 0..R−1, increments per accepted `i_valid`; when an accepted sample brings it from R−1 to 0, a decimation event fires.
- Combs: N cascaded stages per channel, each `y = x − x[−M]`, delay lines of M words, updated only on decimation events; combinational through the chain, registered once at the output.
- Output scaling: if OW ≥ W, sign-extend; if OW < W, keep the top OW bits (truncate LSBs).
- No back-pressure: downstream must accept every `o_valid` pulse.
- All channels share one counter and one `o_valid`; channels never interact arithmetically.

## Timing
- Reset (async assert, sync-released use): integrators, comb delays, counter, `o_data` = 0, `o_valid` = 0.
- Latency: R-th accepted sample at edge k → integrators update at k; `o_data`/`o_valid` registered at edge k+1; `o_valid` high for exactly one cycle.
- Output rate: one `o_valid` per R accepted `i_valid`, independent of gaps in `i_valid`.
- `i_valid` on the cycle a decimation event is being registered: accepted normally, counts toward the next block.
- Reset mid-block: partial count discarded; first output after reset requires R fresh samples.
- Settling: first `N*M` outputs after reset are transient; outputs from index `N*M+1` onward reflect steady state.
- Steady-state gain: `(R*M)^N` before output scaling.

## Configuration
- `CIC_ROUNDING_EN`: when defined and OW < W, output adds 2^(W−OW−1) before dropping LSBs (round half up), saturating at the most positive OW-bit value if the add overflows. When undefined, plain truncation. No effect when OW ≥ W.

## Structure
- Package `cic_pkg`: function `cic_width(N,R,M)` returning W, `pdm_to_signed` mapping function, and the constant maximum N.
- Sub-module `cic_channel` (integrator chain + comb chain for one channel, decimation event as input); top instantiates CH copies via generate plus the shared counter and `o_valid` register.

## Test plan
- Defaults (W=14, OW=16), all channels constant 1, `i_valid` every cycle → `o_valid` every 16 cycles; from 4th output on, every word = +4096.
- Constant 0 → steady words = −4096; alternating 1,0 → steady words = 0.
- Channel 0 all-ones, channel 1 all-zeros simultaneously → +4096 / −4096 respectively, no crosstalk.
- `i_valid` high one cycle in three → `o_valid` once per 48 cycles, same steady values as full rate.
- OW=8, N=3, R=16: all-ones → truncation gives 4096>>6 = 64 (within range); with `CIC_ROUNDING_EN` and input giving 4095, output 64 rather than 63; full-scale positive saturates to 127.
- Drop `i_reset_n` after 10 samples of a block → outputs/valid clear immediately; next `o_valid` exactly 16 accepted samples after release +1 cycle.
